// File: rtl/bellek_yukle_sakla_birimi_pkg.sv
// bellek_yukle_sakla_birimi_pkg
//   Shared encodings for the load/store unit: the bit positions and size codes
//   of the istek_islem_i request-kind field, plus a helper that folds the
//   doubleword size onto word for 32-bit datapaths.
package bellek_yukle_sakla_birimi_pkg;

  // istek_islem_i field layout
  localparam int ISLEM_YAZ      = 3;  // 1 = store
  localparam int ISLEM_ISARETSIZ = 2;  // 1 = zero-extend load result

  typedef enum logic [1:0] {
    BOY_B = 2'd0,
    BOY_H = 2'd1,
    BOY_W = 2'd2,
    BOY_D = 2'd3
  } boy_e;

  // A doubleword request on a 32-bit datapath behaves as a word.
  function automatic logic [1:0] etkin_boy(input int veri_bit, input logic [1:0] boy);
    if (veri_bit == 32 && boy == BOY_D) return BOY_W;
    return boy;
  endfunction

endpackage

// File: rtl/bellek_bekleyen_fifo.sv
// bellek_bekleyen_fifo
//   Pending-load FIFO. Each entry carries an opaque payload plus a cancel
//   (iptal) bit; a flush marks every stored entry cancelled so that its L1
//   response is later consumed and dropped.
// Ports:
//   clk_i, rstn_i      clock, asynchronous active-low reset
//   it_i, veri_i       push strobe and payload (ignored when full)
//   cek_i              pop strobe (ignored when empty)
//   temizle_i          set iptal on all entries
//   bas_o, bas_iptal_o head payload and its cancel bit
//   dolu_o, bos_o      full / empty, from the registered count
module bellek_bekleyen_fifo #(
  parameter int GENISLIK = 8,
  parameter int DERINLIK = 4
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                it_i,
  input  logic [GENISLIK-1:0] veri_i,
  input  logic                cek_i,
  input  logic                temizle_i,
  output logic [GENISLIK-1:0] bas_o,
  output logic                bas_iptal_o,
  output logic                dolu_o,
  output logic                bos_o
);

  localparam int PB = $clog2(DERINLIK);

  logic [GENISLIK-1:0] mem [DERINLIK];
  logic [DERINLIK-1:0] iptal_q;
  logic [PB-1:0]       yaz_q;
  logic [PB-1:0]       oku_q;
  logic [PB:0]         sayac_q;
  logic                it_g;
  logic                cek_g;

  assign dolu_o      = (sayac_q == (PB+1)'(DERINLIK));
  assign bos_o       = (sayac_q == '0);
  assign it_g        = it_i & ~dolu_o;
  assign cek_g       = cek_i & ~bos_o;
  assign bas_o       = mem[oku_q];
  assign bas_iptal_o = iptal_q[oku_q];

  always_ff @(posedge clk_i) begin
    if (it_g) mem[yaz_q] <= veri_i;
  end

  // Pointers wrap naturally because DERINLIK is a power of two.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      yaz_q   <= '0;
      oku_q   <= '0;
      sayac_q <= '0;
      iptal_q <= '0;
    end else begin
      if (it_g)  yaz_q <= yaz_q + 1'b1;
      if (cek_g) oku_q <= oku_q + 1'b1;
      if (it_g && !cek_g)      sayac_q <= sayac_q + 1'b1;
      else if (!it_g && cek_g) sayac_q <= sayac_q - 1'b1;
      if (temizle_i) iptal_q <= '1;
      if (it_g)      iptal_q[yaz_q] <= 1'b0;
    end
  end

endmodule

// File: rtl/bellek_yukle_sakla_birimi.sv
// bellek_yukle_sakla_birimi
//   Load/store unit between the memory stage and the L1 data-cache port.
//   Requests pass combinationally to L1 with byte masks and lane-aligned
//   store data; up to BEKLEYEN_N loads may be outstanding. In-order load
//   responses are extracted, sign/zero-extended and registered with their
//   destination register and tag.
// Optional feature: define BELLEK_HIZALAMA_DENETIM_EN to block misaligned
//   requests (accepted, not forwarded) and report them on hata_o/hata_etiket_o.
//   Without it, offset bits below the access size are simply ignored.
// Ports:
//   istek_*   request channel from the memory stage (valid/ready)
//   temizle_i flush all outstanding loads
//   l1v_*     L1 request channel and L1 response channel
//   yanit_*   writeback result (valid/ready)
//   hata_*    misaligned-access pulse and its tag
//   bos_o     no outstanding loads and no held result
module bellek_yukle_sakla_birimi
  import bellek_yukle_sakla_birimi_pkg::*;
#(
  parameter int VERI_BIT   = 32,
  parameter int ADRES_BIT  = 32,
  parameter int YAZMAC_BIT = 5,
  parameter int ETIKET_BIT = 4,
  parameter int BEKLEYEN_N = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  istek_gecerli_i,
  output logic                  istek_hazir_o,
  input  logic [3:0]            istek_islem_i,
  input  logic [ADRES_BIT-1:0]  istek_adres_i,
  input  logic [VERI_BIT-1:0]   istek_veri_i,
  input  logic [YAZMAC_BIT-1:0] istek_rd_i,
  input  logic [ETIKET_BIT-1:0] istek_etiket_i,
  input  logic                  temizle_i,
  output logic [ADRES_BIT-1:0]  l1v_istek_adres_o,
  output logic                  l1v_istek_gecerli_o,
  output logic                  l1v_istek_yaz_o,
  output logic [VERI_BIT-1:0]   l1v_istek_veri_o,
  output logic [VERI_BIT/8-1:0] l1v_istek_maske_o,
  input  logic                  l1v_istek_hazir_i,
  input  logic [VERI_BIT-1:0]   l1v_veri_i,
  input  logic                  l1v_veri_gecerli_i,
  output logic                  l1v_veri_hazir_o,
  output logic                  yanit_gecerli_o,
  output logic [VERI_BIT-1:0]   yanit_veri_o,
  output logic [YAZMAC_BIT-1:0] yanit_rd_o,
  output logic [ETIKET_BIT-1:0] yanit_etiket_o,
  input  logic                  yanit_hazir_i,
  output logic                  hata_o,
  output logic [ETIKET_BIT-1:0] hata_etiket_o,
  output logic                  bos_o
);

  localparam int BAYT_N  = VERI_BIT / 8;
  localparam int OFS_BIT = $clog2(BAYT_N);
  localparam int FIFO_W  = YAZMAC_BIT + ETIKET_BIT + OFS_BIT + 3;

  function automatic logic [VERI_BIT-1:0] genislet(
    input logic [VERI_BIT-1:0] ham,
    input logic [OFS_BIT-1:0]  ofs,
    input logic [1:0]          boy,
    input logic                isaretsiz
  );
    logic [VERI_BIT-1:0] kayik;
    logic [VERI_BIT-1:0] maske;
    int                  bit_n;
    bit_n = 8 << boy;
    kayik = ham >> {ofs, 3'b000};
    maske = {VERI_BIT{1'b1}} >> (VERI_BIT - bit_n);
    if (!isaretsiz && kayik[bit_n-1]) return kayik | ~maske;
    return kayik & maske;
  endfunction

  logic                  yaz_istek;
  logic                  isaretsiz;
  logic [1:0]            boy;
  logic [OFS_BIT-1:0]    ofs;
  logic [OFS_BIT-1:0]    alt_maske;
  logic [OFS_BIT-1:0]    hizali;
  logic                  hizasiz_engel;
  logic                  gecis;
  logic                  itme;
  logic                  cek;
  logic                  yukle;
  logic                  fifo_dolu;
  logic                  fifo_bos;
  logic [FIFO_W-1:0]     bas;
  logic                  bas_iptal;
  logic [YAZMAC_BIT-1:0] bas_rd;
  logic [ETIKET_BIT-1:0] bas_etiket;
  logic [OFS_BIT-1:0]    bas_ofs;
  logic [1:0]            bas_boy;
  logic                  bas_isaretsiz;
  logic                  basladi_q;
  logic                  vld_p1;
  logic [VERI_BIT-1:0]   veri_p1;
  logic [YAZMAC_BIT-1:0] rd_p1;
  logic [ETIKET_BIT-1:0] etiket_p1;

  // ---- stage p0: request decode and L1 pass-through ----
  assign yaz_istek = istek_islem_i[ISLEM_YAZ];
  assign isaretsiz = istek_islem_i[ISLEM_ISARETSIZ];
  assign boy       = etkin_boy(VERI_BIT, istek_islem_i[1:0]);
  assign ofs       = istek_adres_i[OFS_BIT-1:0];
  assign alt_maske = OFS_BIT'((1 << boy) - 1);
  // Offset bits inside the access size never shift lanes.
  assign hizali    = ofs & ~alt_maske;

`ifdef BELLEK_HIZALAMA_DENETIM_EN
  assign hizasiz_engel = istek_gecerli_i & (|(ofs & alt_maske));
`else
  assign hizasiz_engel = 1'b0;
`endif

  // Full comes from the registered count only, so no response-side term
  // reaches istek_hazir_o.
  assign gecis               = ~temizle_i & ~hizasiz_engel & (yaz_istek | ~fifo_dolu);
  assign l1v_istek_gecerli_o = istek_gecerli_i & gecis;
  assign istek_hazir_o       = hizasiz_engel | (l1v_istek_hazir_i & gecis);
  assign l1v_istek_adres_o   = istek_adres_i;
  assign l1v_istek_yaz_o     = yaz_istek;
  assign l1v_istek_veri_o    = istek_veri_i << {hizali, 3'b000};

  always_comb begin
    l1v_istek_maske_o = '1;
    if (yaz_istek) l1v_istek_maske_o = BAYT_N'((1 << (1 << boy)) - 1) << hizali;
  end

  assign itme = istek_gecerli_i & l1v_istek_hazir_i & gecis & ~yaz_istek;

  bellek_bekleyen_fifo #(
    .GENISLIK (FIFO_W),
    .DERINLIK (BEKLEYEN_N)
  ) u_fifo (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .it_i        (itme),
    .veri_i      ({istek_rd_i, istek_etiket_i, hizali, boy, isaretsiz}),
    .cek_i       (cek),
    .temizle_i   (temizle_i),
    .bas_o       (bas),
    .bas_iptal_o (bas_iptal),
    .dolu_o      (fifo_dolu),
    .bos_o       (fifo_bos)
  );

  assign {bas_rd, bas_etiket, bas_ofs, bas_boy, bas_isaretsiz} = bas;

  // A response with nothing pending is handshaken and dropped.
  assign l1v_veri_hazir_o = basladi_q & (~vld_p1 | yanit_hazir_i);
  assign cek              = l1v_veri_gecerli_i & l1v_veri_hazir_o & ~fifo_bos;
  // A flush in the same cycle cancels the entry being popped as well.
  assign yukle            = cek & ~bas_iptal & ~temizle_i;

  // ---- stage p1: writeback result register ----
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      basladi_q <= 1'b0;
      vld_p1    <= 1'b0;
      veri_p1   <= '0;
      rd_p1     <= '0;
      etiket_p1 <= '0;
    end else begin
      basladi_q <= 1'b1;
      if (temizle_i) begin
        vld_p1 <= 1'b0;
      end else if (yukle) begin
        vld_p1    <= 1'b1;
        veri_p1   <= genislet(l1v_veri_i, bas_ofs, bas_boy, bas_isaretsiz);
        rd_p1     <= bas_rd;
        etiket_p1 <= bas_etiket;
      end else if (yanit_hazir_i) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign yanit_gecerli_o = vld_p1;
  assign yanit_veri_o    = veri_p1;
  assign yanit_rd_o      = rd_p1;
  assign yanit_etiket_o  = etiket_p1;
  assign bos_o           = basladi_q & fifo_bos & ~vld_p1;

`ifdef BELLEK_HIZALAMA_DENETIM_EN
  logic                  hata_p1;
  logic [ETIKET_BIT-1:0] hata_etiket_p1;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hata_p1        <= 1'b0;
      hata_etiket_p1 <= '0;
    end else begin
      hata_p1 <= hizasiz_engel;
      if (hizasiz_engel) hata_etiket_p1 <= istek_etiket_i;
    end
  end

  assign hata_o        = hata_p1;
  assign hata_etiket_o = hata_etiket_p1;
`else
  assign hata_o        = 1'b0;
  assign hata_etiket_o = '0;
`endif

endmodule

// File: tb/tb_bellek_yukle_sakla_birimi.sv
// Testbench for bellek_yukle_sakla_birimi: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based behavioural model.
module tb_bellek_yukle_sakla_birimi;

  localparam int VB = 32;
  localparam int AB = 32;
  localparam int RB = 5;
  localparam int TB = 4;
  localparam int N  = 4;
  localparam int BY = VB / 8;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          istek_gecerli_i = 1'b0;
  logic          istek_hazir_o;
  logic [3:0]    istek_islem_i = '0;
  logic [AB-1:0] istek_adres_i = '0;
  logic [VB-1:0] istek_veri_i = '0;
  logic [RB-1:0] istek_rd_i = '0;
  logic [TB-1:0] istek_etiket_i = '0;
  logic          temizle_i = 1'b0;
  logic [AB-1:0] l1v_istek_adres_o;
  logic          l1v_istek_gecerli_o;
  logic          l1v_istek_yaz_o;
  logic [VB-1:0] l1v_istek_veri_o;
  logic [BY-1:0] l1v_istek_maske_o;
  logic          l1v_istek_hazir_i = 1'b1;
  logic [VB-1:0] l1v_veri_i = '0;
  logic          l1v_veri_gecerli_i = 1'b0;
  logic          l1v_veri_hazir_o;
  logic          yanit_gecerli_o;
  logic [VB-1:0] yanit_veri_o;
  logic [RB-1:0] yanit_rd_o;
  logic [TB-1:0] yanit_etiket_o;
  logic          yanit_hazir_i = 1'b1;
  logic          hata_o;
  logic [TB-1:0] hata_etiket_o;
  logic          bos_o;

  bellek_yukle_sakla_birimi #(
    .VERI_BIT(VB), .ADRES_BIT(AB), .YAZMAC_BIT(RB), .ETIKET_BIT(TB), .BEKLEYEN_N(N)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .istek_gecerli_i(istek_gecerli_i), .istek_hazir_o(istek_hazir_o),
    .istek_islem_i(istek_islem_i), .istek_adres_i(istek_adres_i),
    .istek_veri_i(istek_veri_i), .istek_rd_i(istek_rd_i),
    .istek_etiket_i(istek_etiket_i), .temizle_i(temizle_i),
    .l1v_istek_adres_o(l1v_istek_adres_o), .l1v_istek_gecerli_o(l1v_istek_gecerli_o),
    .l1v_istek_yaz_o(l1v_istek_yaz_o), .l1v_istek_veri_o(l1v_istek_veri_o),
    .l1v_istek_maske_o(l1v_istek_maske_o), .l1v_istek_hazir_i(l1v_istek_hazir_i),
    .l1v_veri_i(l1v_veri_i), .l1v_veri_gecerli_i(l1v_veri_gecerli_i),
    .l1v_veri_hazir_o(l1v_veri_hazir_o),
    .yanit_gecerli_o(yanit_gecerli_o), .yanit_veri_o(yanit_veri_o),
    .yanit_rd_o(yanit_rd_o), .yanit_etiket_o(yanit_etiket_o),
    .yanit_hazir_i(yanit_hazir_i),
    .hata_o(hata_o), .hata_etiket_o(hata_etiket_o), .bos_o(bos_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
    n_chk++;
    if (gercek !== beklenen) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", ad, gercek, beklenen, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [RB-1:0] rd;
    logic [TB-1:0] tag;
    int            aoff;
    int            nb;
    bit            uns;
    bit            iptal;
  } bek_t;

  bek_t          kuyruk[$];
  bit            m_bas = 0;
  bit            m_vld = 0;
  logic [VB-1:0] m_veri = '0;
  logic [RB-1:0] m_rd = '0;
  logic [TB-1:0] m_tag = '0;
  bit            m_hata = 0;
  logic [TB-1:0] m_hetk = '0;

  initial begin
    forever begin
      int s, nb, off, aoff;
      bit mis, engel, dolu, gec, e_gec, e_haz, e_vhaz, e_bos, yukle;
      logic [63:0] d, v;
      bek_t h;
      @(negedge clk_i);
      if (!rstn_i) begin
        kuyruk.delete();
        m_bas = 0; m_vld = 0; m_veri = '0; m_rd = '0; m_tag = '0;
        m_hata = 0; m_hetk = '0;
      end
      s = int'(istek_islem_i[1:0]);
      if (VB == 32 && s == 3) s = 2;
      nb   = 1 << s;
      off  = int'(istek_adres_i & AB'(BY - 1));
      aoff = off - (off % nb);
      mis  = 0;
`ifdef BELLEK_HIZALAMA_DENETIM_EN
      mis  = (off % nb) != 0;
`endif
      engel  = istek_gecerli_i && mis;
      dolu   = kuyruk.size() == N;
      gec    = !temizle_i && !engel && (istek_islem_i[3] || !dolu);
      e_gec  = istek_gecerli_i && gec;
      e_haz  = engel || (l1v_istek_hazir_i && gec);
      e_vhaz = m_bas && (!m_vld || yanit_hazir_i);
      e_bos  = m_bas && kuyruk.size() == 0 && !m_vld;

      chk("l1v_gecerli", 64'(l1v_istek_gecerli_o), 64'(e_gec));
      chk("istek_hazir", 64'(istek_hazir_o), 64'(e_haz));
      chk("veri_hazir", 64'(l1v_veri_hazir_o), 64'(e_vhaz));
      chk("bos", 64'(bos_o), 64'(e_bos));
      chk("yanit_gecerli", 64'(yanit_gecerli_o), 64'(m_vld));
      chk("hata", 64'(hata_o), 64'(m_hata));
      chk("hata_etiket", 64'(hata_etiket_o), 64'(m_hetk));
      if (e_gec) begin
        chk("l1v_adres", 64'(l1v_istek_adres_o), 64'(istek_adres_i));
        chk("l1v_yaz", 64'(l1v_istek_yaz_o), 64'(istek_islem_i[3]));
        if (istek_islem_i[3]) begin
          d = 64'(istek_veri_i) << (8 * aoff);
          chk("st_veri", 64'(l1v_istek_veri_o), d & ((64'd1 << VB) - 1));
          chk("st_maske", 64'(l1v_istek_maske_o), (((64'd1 << nb) - 1) << aoff) & ((64'd1 << BY) - 1));
        end else begin
          chk("ld_maske", 64'(l1v_istek_maske_o), (64'd1 << BY) - 1);
        end
      end
      if (m_vld) begin
        chk("yanit_veri", 64'(yanit_veri_o), 64'(m_veri));
        chk("yanit_rd", 64'(yanit_rd_o), 64'(m_rd));
        chk("yanit_etiket", 64'(yanit_etiket_o), 64'(m_tag));
      end

      if (rstn_i) begin
        yukle = 0;
        if (l1v_veri_gecerli_i && e_vhaz && kuyruk.size() > 0) begin
          h = kuyruk.pop_front();
          if (!h.iptal && !temizle_i) begin
            yukle = 1;
            v = '0;
            for (int i = 0; i < h.nb; i++)
              v[8*i +: 8] = l1v_veri_i[8*(h.aoff+i) +: 8];
            if (!h.uns && v[8*h.nb-1])
              for (int i = h.nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
            m_veri = v[VB-1:0];
            m_rd   = h.rd;
            m_tag  = h.tag;
          end
        end
        if (temizle_i) m_vld = 0;
        else if (yukle) m_vld = 1;
        else if (yanit_hazir_i) m_vld = 0;
        if (temizle_i) foreach (kuyruk[i]) kuyruk[i].iptal = 1;
        if (istek_gecerli_i && l1v_istek_hazir_i && gec && !istek_islem_i[3]) begin
          h.rd = istek_rd_i; h.tag = istek_etiket_i; h.aoff = aoff; h.nb = nb;
          h.uns = istek_islem_i[2]; h.iptal = 0;
          kuyruk.push_back(h);
        end
        m_hata = engel;
        if (engel) m_hetk = istek_etiket_i;
        m_bas = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic ileri();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bosta();
    istek_gecerli_i = 0; temizle_i = 0; l1v_veri_gecerli_i = 0;
    l1v_istek_hazir_i = 1; yanit_hazir_i = 1;
  endtask

  task automatic istek(input logic [3:0] islem, input logic [AB-1:0] adr,
                       input logic [VB-1:0] veri, input logic [RB-1:0] rd, input logic [TB-1:0] tag);
    istek_gecerli_i = 1; istek_islem_i = islem; istek_adres_i = adr;
    istek_veri_i = veri; istek_rd_i = rd; istek_etiket_i = tag;
  endtask

  task automatic bosalt();
    bit tamam;
    tamam = 0;
    bosta();
    l1v_veri_gecerli_i = 1;
    l1v_veri_i = $urandom;
    for (int i = 0; i < 20 && !tamam; i++) begin
      @(negedge clk_i);
      if (bos_o) tamam = 1;
      ileri();
    end
    chk("drain_done", 64'(tamam), 64'd1);
    bosta();
  endtask

  initial begin
    bosta();
    rstn_i = 0;
    repeat (2) ileri();
    @(negedge clk_i);
    chk("rst_yanit", 64'(yanit_gecerli_o), 64'd0);
    chk("rst_bos", 64'(bos_o), 64'd0);
    chk("rst_hata", 64'(hata_o), 64'd0);
    chk("rst_vhaz", 64'(l1v_veri_hazir_o), 64'd0);
    ileri();
    rstn_i = 1;
    ileri();

    // LB at 0x1003, L1 word 0x80FF_FF00 -> 0xFFFF_FF80
    istek(4'b0000, 32'h1003, '0, 5'd7, 4'h9);
    @(negedge clk_i);
    chk("lb_fwd", 64'(l1v_istek_gecerli_o), 64'd1);
    chk("lb_mask", 64'(l1v_istek_maske_o), 64'hF);
    ileri();
    istek_gecerli_i = 0; l1v_veri_gecerli_i = 1; l1v_veri_i = 32'h80FF_FF00; yanit_hazir_i = 0;
    @(negedge clk_i);
    chk("lb_not_yet", 64'(yanit_gecerli_o), 64'd0);
    ileri();
    l1v_veri_gecerli_i = 0;
    @(negedge clk_i);
    chk("lb_vld", 64'(yanit_gecerli_o), 64'd1);
    chk("lb_data", 64'(yanit_veri_o), 64'hFFFF_FF80);
    chk("lb_rd", 64'(yanit_rd_o), 64'd7);
    chk("lb_tag", 64'(yanit_etiket_o), 64'h9);
    ileri();
    yanit_hazir_i = 1;
    ileri();

    // SH 0xABCD at 0x2002
    istek(4'b1001, 32'h2002, 32'h0000_ABCD, 5'd0, 4'h1);
    @(negedge clk_i);
    chk("sh_mask", 64'(l1v_istek_maske_o), 64'hC);
    chk("sh_data", 64'(l1v_istek_veri_o), 64'hABCD_0000);
    chk("sh_yaz", 64'(l1v_istek_yaz_o), 64'd1);
    ileri();
    istek_gecerli_i = 0;
    @(negedge clk_i);
    chk("sh_no_yanit", 64'(yanit_gecerli_o), 64'd0);
    chk("sh_bos", 64'(bos_o), 64'd1);
    ileri();

    // Four LW fill the FIFO; fifth blocked, a store still passes
    for (int i = 0; i < 4; i++) begin
      istek(4'b0010, 32'h100 + 32'(4*i), '0, 5'(i+1), 4'(i));
      @(negedge clk_i);
      chk("lw_acc", 64'(istek_hazir_o), 64'd1);
      ileri();
    end
    istek(4'b0010, 32'h200, '0, 5'd9, 4'd9);
    @(negedge clk_i);
    chk("lw5_blk", 64'(istek_hazir_o), 64'd0);
    chk("lw5_nofwd", 64'(l1v_istek_gecerli_o), 64'd0);
    ileri();
    istek(4'b1010, 32'h300, 32'h5555_AAAA, 5'd0, 4'd2);
    @(negedge clk_i);
    chk("st_full", 64'(istek_hazir_o), 64'd1);
    ileri();
    istek(4'b0010, 32'h200, '0, 5'd9, 4'd9);
    l1v_veri_gecerli_i = 1; l1v_veri_i = 32'h1111_1111;
    @(negedge clk_i);
    chk("lw5_still_blk", 64'(istek_hazir_o), 64'd0);
    ileri();
    l1v_veri_gecerli_i = 0;
    @(negedge clk_i);
    chk("lw5_acc", 64'(istek_hazir_o), 64'd1);
    ileri();
    bosalt();

    // Flush with two loads outstanding
    istek(4'b0010, 32'h400, '0, 5'd3, 4'd3); ileri();
    istek(4'b0001, 32'h406, '0, 5'd4, 4'd4); ileri();
    istek_gecerli_i = 0; temizle_i = 1; ileri();
    temizle_i = 0; l1v_veri_gecerli_i = 1; l1v_veri_i = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) l1v_veri_gecerli_i = 0;
      @(negedge clk_i);
      chk("fl_no_yanit", 64'(yanit_gecerli_o), 64'd0);
      ileri();
    end
    @(negedge clk_i);
    chk("fl_bos", 64'(bos_o), 64'd1);
    ileri();

    // Backpressure: held result stays stable, response not accepted
    istek(4'b0010, 32'h500, '0, 5'd10, 4'd10); ileri();
    istek(4'b0010, 32'h504, '0, 5'd11, 4'd11); ileri();
    istek_gecerli_i = 0; yanit_hazir_i = 0;
    l1v_veri_gecerli_i = 1; l1v_veri_i = 32'h1234_5678; ileri();
    l1v_veri_i = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      chk("bp_vhaz", 64'(l1v_veri_hazir_o), 64'd0);
      chk("bp_stable", 64'(yanit_veri_o), 64'h1234_5678);
      ileri();
    end
    yanit_hazir_i = 1;
    @(negedge clk_i);
    chk("bp_release", 64'(l1v_veri_hazir_o), 64'd1);
    ileri();
    l1v_veri_gecerli_i = 0;
    @(negedge clk_i);
    chk("bp_second", 64'(yanit_veri_o), 64'hDEAD_BEEF);
    chk("bp_second_tag", 64'(yanit_etiket_o), 64'd11);
    ileri();
    bosalt();

    // Misaligned LW at 0x3002
    istek(4'b0010, 32'h3002, '0, 5'd12, 4'd5);
    @(negedge clk_i);
`ifdef BELLEK_HIZALAMA_DENETIM_EN
    chk("mis_nofwd", 64'(l1v_istek_gecerli_o), 64'd0);
    chk("mis_hazir", 64'(istek_hazir_o), 64'd1);
    ileri();
    istek_gecerli_i = 0;
    @(negedge clk_i);
    chk("mis_hata", 64'(hata_o), 64'd1);
    chk("mis_tag", 64'(hata_etiket_o), 64'd5);
    ileri();
`else
    chk("mis_fwd", 64'(l1v_istek_gecerli_o), 64'd1);
    chk("mis_mask", 64'(l1v_istek_maske_o), 64'hF);
    ileri();
    istek_gecerli_i = 0;
    @(negedge clk_i);
    chk("mis_nohata", 64'(hata_o), 64'd0);
    ileri();
    bosalt();
`endif

    // Reset mid-operation
    istek(4'b0010, 32'h600, '0, 5'd1, 4'd1); ileri();
    istek_gecerli_i = 0; rstn_i = 0;
    @(negedge clk_i);
    chk("mr_bos", 64'(bos_o), 64'd0);
    chk("mr_yanit", 64'(yanit_gecerli_o), 64'd0);
    ileri();
    rstn_i = 1; ileri();
    @(negedge clk_i);
    chk("mr_empty", 64'(bos_o), 64'd1);
    ileri();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      logic [AB-1:0] a;
      a = $urandom;
      if ($urandom_range(1) == 1) a = a & ~AB'(BY - 1);
      istek_gecerli_i    = ($urandom_range(9) < 6);
      istek_islem_i      = 4'($urandom_range(15));
      istek_adres_i      = a;
      istek_veri_i       = $urandom;
      istek_rd_i         = RB'($urandom);
      istek_etiket_i     = TB'($urandom);
      l1v_istek_hazir_i  = ($urandom_range(9) < 8);
      l1v_veri_gecerli_i = ($urandom_range(1) == 1);
      l1v_veri_i         = $urandom;
      yanit_hazir_i      = ($urandom_range(9) < 7);
      temizle_i          = ($urandom_range(49) == 0);
      rstn_i             = ($urandom_range(999) != 0);
      ileri();
    end
    bosta();
    rstn_i = 1;
    repeat (3) ileri();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
